load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
// - Sits between the rv32i execute stage and data_memory. Converts core
//   LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned accesses on the
//   data_memory port (address/read/write/wdata/rdata).
// - data_memory has no byte enables, so SB/SH become read-modify-write.
//   Loads are lane-extracted and sign- or zero-extended.
// - Misaligned and out-of-window accesses are rejected with resp_err and
//   never reach memory.
// PARAMETERS
// - AW    32      address width
// - BASE  'h1000  first byte address of the data window
// - SIZE  1024    window size in bytes; legal: BASE <= addr < BASE+SIZE
// PORTS
// - clk          in   1   single clock, rising edge
// - rst_n        in   1   asynchronous, active-low reset
// - req_valid    in   1   core request valid
// - req_ready    out  1   unit can accept; 1 only in IDLE
// - req_we       in   1   1 = store, 0 = load
// - req_funct3   in   3   RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
// - req_addr     in   AW  byte address
// - req_wdata    in   32  store data, right-justified
// - resp_valid   out  1   response valid, held until resp_ready
// - resp_ready   in   1   core accepts the response
// - resp_rdata   out  32  extended load data; 0 for stores and errors
// - resp_err     out  1   misaligned, out-of-window or illegal funct3
// - mem_address  out  AW  word-aligned address {addr[AW-1:2],2'b00}
// - mem_read     out  1   to data_memory read
// - mem_write    out  1   to data_memory write; data_memory writes on the next clk edge
// - mem_wdata    out  32  to data_memory wdata
// - mem_rdata    in   32  from data_memory; combinational, valid in the same cycle
// BEHAVIOUR
// - Reset: state = IDLE. req_ready=1. resp_valid=0, resp_err=0, resp_rdata=0.
//   mem_read=0, mem_write=0, mem_address=0, mem_wdata=0.
// - Accept: req_valid && req_ready. Capture we/funct3/addr/wdata into
//   registers. Inputs are ignored outside IDLE.
// - Error check at accept time:
//   - H/HU with addr[0] != 0, or W with addr[1:0] != 0: error.
//   - addr outside the window: error.
//   - funct3 011/110/111: error. Stores also reject funct3 1xx.
//   - Any error: next state DONE with resp_err=1. No memory cycle.
// - FSM states: IDLE, LOAD, RMW_RD, WR, DONE.
//   - IDLE -> LOAD     legal load
//   - IDLE -> RMW_RD   legal SB/SH
//   - IDLE -> WR       legal SW
//   - IDLE -> DONE     error
//   - LOAD: mem_read=1. Extract the byte/half at addr[1:0], extend it, and
//     register it into resp_rdata. -> DONE
//   - RMW_RD: mem_read=1. Merge the store byte/half into mem_rdata at
//     addr[1:0] and register the result into mem_wdata. -> WR
//   - WR: mem_write=1, mem_read=0. For SW, mem_wdata = captured wdata. -> DONE
//   - DONE: resp_valid=1. Leave to IDLE on resp_ready. Otherwise hold the
//     response stable.
// - mem_read/mem_write are registered state decodes. They are never both 1.
// - Latency, accept-to-resp_valid: load 2, SW 2, SB/SH 3, error 1 cycle.
//   No back-to-back accept; req_ready returns the cycle after the response
//   handshake.
// - Lane rules, with a = addr[1:0]:
//   - Byte lane = mem_rdata[8a+7:8a]. Half lane = mem_rdata[16a[1]+15:16a[1]].
//   - B/H sign-extend from the lane MSB. BU/HU zero-extend.
// - Reset mid-operation: FSM goes to IDLE immediately and mem_write drops
//   asynchronously. An aborted RMW leaves memory unchanged unless the WR
//   edge has already occurred. No response is issued.
// STRUCTURE
// - Package lsu_pkg:
//   - funct3 localparams F3_B/H/W/BU/HU
//   - state encodings S_IDLE/S_LOAD/S_RMW_RD/S_WR/S_DONE (3-bit)
// - Sub-module lsu_align, combinational: (rdata, a, funct3, wdata) ->
//   (load_ext, store_merged). Shared by the LOAD and RMW_RD paths.
// - Top level holds the FSM, request/response registers and window check.
// TESTING
// - Memory model: data_memory behavioural model, BASE='h1000, preloaded
//   word 'h1000 = 32'h8899AABB.
// - LB 'h1001 -> resp_rdata=32'hFFFFFFAA, err=0, resp_valid 2 cycles
//   after accept. LBU 'h1001 -> 32'h000000AA.
// - SB 'h1002, wdata 32'h00000011 -> one read then one write cycle;
//   mem word becomes 32'h8811AABB. resp_valid 3 cycles after accept.
// - LW 'h1002 -> resp_err=1, resp_rdata=0. mem_read and mem_write stay 0
//   throughout. resp_valid 1 cycle after accept.
// - SW 'h0FFC (below BASE) -> resp_err=1, no write. Then SW 'h1004 with
//   32'hDEADBEEF -> later LW 'h1004 returns 32'hDEADBEEF.
// - Hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable,
//   req_ready=0. A second req_valid during the hold is not accepted.
// - Assert rst_n=0 during RMW_RD of SH 'h1000 -> mem_write never pulses,
//   word unchanged, all outputs at reset values, req_ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WR     = 3'd3,
    S_DONE   = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Lane logic shared by the load and read-modify-write paths: picks the byte or
// half addressed by a out of a memory word and extends it, and merges store
// data into that lane of the word for the write-back.
module lsu_align import lsu_pkg::*; (
  input  logic [31:0] rdata,
  input  logic [1:0]  a,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic [31:0] store_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane extraction, load extension and store merge for the addressed lane.
  always_comb begin
    w_byte       = rdata[{a, 3'b000} +: 8];
    w_half       = rdata[{a[1], 4'b0000} +: 16];
    load_ext     = 32'h0000_0000;
    store_merged = rdata;
    case (funct3)
      F3_B: begin
        load_ext                          = {{24{w_byte[7]}}, w_byte};
        store_merged[{a, 3'b000} +: 8]    = wdata[7:0];
      end
      F3_H: begin
        load_ext                          = {{16{w_half[15]}}, w_half};
        store_merged[{a[1], 4'b0000} +: 16] = wdata[15:0];
      end
      F3_W: begin
        load_ext     = rdata;
        store_merged = wdata;
      end
      F3_BU: begin
        load_ext = {24'h00_0000, w_byte};
      end
      F3_HU: begin
        load_ext = {16'h0000, w_half};
      end
      default: begin
        load_ext     = 32'h0000_0000;
        store_merged = rdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-only data memory.
// Sub-word stores become read-modify-write; loads are lane-extracted and
// extended. Misaligned, out-of-window or illegal requests are answered with
// an error and never touch memory.
module load_store_unit import lsu_pkg::*; #(
  parameter int              AW   = 32,
  parameter logic [AW-1:0]   BASE = AW'(32'h0000_1000),
  parameter int unsigned     SIZE = 32'd1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_address,
  output logic          mem_read,
  output logic          mem_write,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  // One extra bit so BASE+SIZE cannot wrap at the top of the address space.
  localparam logic [AW:0] WIN_LO = {1'b0, BASE};
  localparam logic [AW:0] WIN_HI = WIN_LO + (AW+1)'(SIZE);

  lsu_state_e    r_state;
  logic          r_req_ready;
  logic [2:0]    r_f3;
  logic [1:0]    r_lane;
  logic [31:0]   r_wdata;
  logic          r_resp_valid;
  logic          r_resp_err;
  logic [31:0]   r_resp_rdata;
  logic [AW-1:0] r_mem_address;
  logic          r_mem_read;
  logic          r_mem_write;
  logic [31:0]   r_mem_wdata;

  logic          w_in_window;
  logic          w_err;
  logic [31:0]   w_load_ext;
  logic [31:0]   w_store_merged;

  // Request legality: funct3 vs direction, natural alignment and data window.
  always_comb begin
    w_in_window = ({1'b0, req_addr} >= WIN_LO) && ({1'b0, req_addr} < WIN_HI);
    w_err       = 1'b1;
    case (req_funct3)
      F3_B:    w_err = 1'b0;
      F3_H:    w_err = req_addr[0];
      F3_W:    w_err = |req_addr[1:0];
      F3_BU:   w_err = req_we;
      F3_HU:   w_err = req_we | req_addr[0];
      default: w_err = 1'b1;
    endcase
    if (!w_in_window) begin
      w_err = 1'b1;
    end else begin
      w_err = w_err;
    end
  end

  lsu_align u_align (
    .rdata        (mem_rdata),
    .a            (r_lane),
    .funct3       (r_f3),
    .wdata        (r_wdata),
    .load_ext     (w_load_ext),
    .store_merged (w_store_merged)
  );

  // Control FSM; every output is a register updated together with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_req_ready   <= 1'b1;
      r_f3          <= 3'b000;
      r_lane        <= 2'b00;
      r_wdata       <= 32'h0000_0000;
      r_resp_valid  <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_rdata  <= 32'h0000_0000;
      r_mem_address <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_wdata   <= 32'h0000_0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_f3         <= req_funct3;
            r_lane       <= req_addr[1:0];
            r_wdata      <= req_wdata;
            r_resp_rdata <= 32'h0000_0000;
            r_req_ready  <= 1'b0;
            if (w_err) begin
              r_state      <= S_DONE;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else begin
              r_mem_address <= {req_addr[AW-1:2], 2'b00};
              if (!req_we) begin
                r_state    <= S_LOAD;
                r_mem_read <= 1'b1;
              end else if (req_funct3 == F3_W) begin
                r_state     <= S_WR;
                r_mem_write <= 1'b1;
                r_mem_wdata <= req_wdata;
              end else begin
                r_state    <= S_RMW_RD;
                r_mem_read <= 1'b1;
              end
            end
          end
        end
        S_LOAD: begin
          r_resp_rdata <= w_load_ext;
          r_mem_read   <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= S_DONE;
        end
        S_RMW_RD: begin
          r_mem_wdata <= w_store_merged;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b1;
          r_state     <= S_WR;
        end
        S_WR: begin
          r_mem_write  <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= S_DONE;
        end
        S_DONE: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0000_0000;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_mem_read   <= 1'b0;
          r_mem_write  <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_err    = r_resp_err;
  assign resp_rdata  = r_resp_rdata;
  assign mem_address = r_mem_address;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_wdata   = r_mem_wdata;

endmodule
